// File: rtl/markov_predictor.sv
// Markov-chain opponent model for rock-paper-scissors. Saturating transition counts indexed by
// the last HIST rounds predict the player's next move; the CPU choice is the move that beats it.
module markov_predictor #(
  parameter int HIST    = 1,
  parameter int USE_CPU = 1,
  parameter int CNT_W   = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [1:0] move,
  input  logic [1:0] cpu_move,
  output logic       pred_valid,
  output logic [1:0] predicted,
  output logic [1:0] choice,
  output logic       move_err
);

  localparam int unsigned RADIX = (USE_CPU != 0) ? 9 : 3;
  localparam int unsigned N_CTX = RADIX ** HIST;
  localparam int unsigned N_LOW = N_CTX / RADIX;
  localparam int          CTX_W = $clog2(N_CTX);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_UPD,
    S_PRED,
    S_DONE
  } state_t;

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [CTX_W-1:0] r_init_row;
  logic [CTX_W-1:0] r_ctx;
  logic [CTX_W-1:0] w_new_ctx;
  logic [1:0]       r_mv;
  logic [1:0]       r_cm;
  logic [1:0]       r_tie_ptr;
  logic [1:0]       r_rr;
  logic [1:0]       r_predicted;
  logic [1:0]       r_choice;
  logic             r_move_err;
  logic [CNT_W-1:0] r_table [N_CTX][3];
  logic [CNT_W-1:0] w_cur_row [3];
  logic [CNT_W-1:0] w_upd_row [3];
  logic [CNT_W-1:0] w_max;
  logic [1:0]       w_p0;
  logic [1:0]       w_p1;
  logic [1:0]       w_p2;
  logic [1:0]       w_pick;
  logic [3:0]       w_sym;
  logic             w_restart;
  logic             w_illegal;
  logic             w_handshake;
  logic             w_accept;
  logic             w_sat;

  assign w_restart   = !reset || clear;
  assign w_illegal   = (move == 2'd3) || ((USE_CPU != 0) && (cpu_move == 2'd3));
  assign w_handshake = move_valid && (r_state == S_IDLE);
  assign w_accept    = w_handshake && !w_illegal;

  // Round symbol is one base-RADIX digit; the oldest digit falls off the top of the context.
  assign w_sym     = (USE_CPU != 0) ? (4'(r_mv) * 4'd3 + 4'(r_cm)) : 4'(r_mv);
  assign w_new_ctx = CTX_W'((32'(r_ctx) % N_LOW) * RADIX + 32'(w_sym));

  // NOTE: synchronous restart; clear is folded into reset so both take exactly the same path.
  always_ff @(posedge clock) begin
    if (w_restart) r_state <= S_INIT;
    else           r_state <= w_next_state;
  end

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:  if (r_init_row == CTX_W'(N_CTX - 1)) w_next_state = S_IDLE;
      S_IDLE:  if (w_accept) w_next_state = S_UPD;
      S_UPD:   w_next_state = S_PRED;
      S_PRED:  w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_INIT;
    endcase
  end

  always_comb begin
    move_ready = 1'b0;
    pred_valid = 1'b0;
    case (r_state)
      S_IDLE:  move_ready = 1'b1;
      S_DONE:  pred_valid = 1'b1;
      default: ;
    endcase
  end

  assign predicted = r_predicted;
  assign choice    = r_choice;
  assign move_err  = r_move_err;

  // UPD and PRED both work on the row selected by r_ctx (old context, then new context).
  always_comb begin
    for (int k = 0; k < 3; k++) w_cur_row[k] = r_table[r_ctx][k];
  end

  assign w_sat = (w_cur_row[r_mv] == MAX_CNT);

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_upd_row[k] = w_sat ? (w_cur_row[k] >> 1) : w_cur_row[k];
      if (2'(k) == r_mv) w_upd_row[k] = w_upd_row[k] + CNT_W'(1);
    end
  end

  // Argmax with a rotating tie-break start; an empty row falls back to the free-running rr.
  always_comb begin
    w_max = w_cur_row[0];
    if (w_cur_row[1] > w_max) w_max = w_cur_row[1];
    if (w_cur_row[2] > w_max) w_max = w_cur_row[2];
    w_p0 = r_tie_ptr;
    w_p1 = inc3(w_p0);
    w_p2 = inc3(w_p1);
    if (w_max == '0)                  w_pick = r_rr;
    else if (w_cur_row[w_p0] == w_max) w_pick = w_p0;
    else if (w_cur_row[w_p1] == w_max) w_pick = w_p1;
    else                               w_pick = w_p2;
  end

  always_ff @(posedge clock) begin
    if (w_restart) begin
      r_init_row  <= '0;
      r_ctx       <= '0;
      r_mv        <= 2'd0;
      r_cm        <= 2'd0;
      r_tie_ptr   <= 2'd0;
      r_rr        <= 2'd0;
      r_predicted <= 2'd0;
      r_choice    <= 2'd1;
      r_move_err  <= 1'b0;
    end else begin
      r_rr       <= inc3(r_rr);
      r_move_err <= w_handshake && w_illegal;
      case (r_state)
        S_INIT: r_init_row <= r_init_row + CTX_W'(1);
        S_IDLE: begin
          if (w_accept) begin
            r_mv <= move;
            r_cm <= cpu_move;
          end
        end
        S_UPD:  r_ctx <= w_new_ctx;
        S_PRED: begin
          r_predicted <= w_pick;
          r_choice    <= inc3(w_pick);
          r_tie_ptr   <= inc3(r_tie_ptr);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the table has no reset; INIT walks every row to zero, so it stays plain storage.
  always_ff @(posedge clock) begin
    if (!w_restart) begin
      if (r_state == S_INIT) begin
        for (int k = 0; k < 3; k++) r_table[r_init_row][k] <= '0;
      end else if (r_state == S_UPD) begin
        for (int k = 0; k < 3; k++) r_table[r_ctx][k] <= w_upd_row[k];
      end
    end
  end

endmodule
